frame_sync_rx: RTL and testbench
================================

// Module: frame_sync_rx
// PURPOSE
//  Upstream controller for the NDATA-bit serial-in/parallel-out shift register.
//  - Hunts a received bit stream for a SYNC_LEN-bit sync word.
//  - Forwards the next NDATA payload bits to the shift register as sr_din plus an active-low shift strobe.
//  - Pulses frame_done once the shift register holds a complete frame; aborts on inter-bit timeout.
// PARAMETERS
//  NDATA      128        payload bits per frame; must match the downstream shift register
//  SYNC_LEN   16         sync word length in bits
//  SYNC_WORD  16'hA5F0   sync pattern; MSB is received first
//  MAX_ERR    0          max Hamming distance still accepted as sync (0 = exact match)
//  TIMEOUT    1024       max clk cycles between bit_vld strobes in PAYLOAD before abort
// PORTS
//  clk         in   1              clock
//  rst         in   1              reset, asynchronous, active-low
//  bit_in      in   1              received bit, qualified by bit_vld
//  bit_vld     in   1              1-cycle strobe, one per received bit
//  sr_din      out  1              serial data to shift register
//  sr_ena_n    out  1              shift strobe to shift register, active-low, 1 cycle per payload bit
//  frame_done  out  1              1-cycle pulse: shift register output holds a complete frame
//  frame_err   out  1              1-cycle pulse: payload aborted on timeout
//  busy        out  1              high while in PAYLOAD or DONE
//  sync_hits   out  8              count of sync detections; saturates at 8'hFF
// BEHAVIOUR
//  Reset (rst=0): state=HUNT, hist=0, bit_cnt=0, tmo_cnt=0.
//   Outputs at reset: sr_din=0, sr_ena_n=1, frame_done=0, frame_err=0, busy=0, sync_hits=0.
//  All outputs are registered. Latency is 1 cycle from bit_vld to the matching sr_ena_n low cycle.
//  HUNT:
//   - On bit_vld: hist <= {hist[SYNC_LEN-2:0], bit_in}.
//   - Match test uses the updated history value; match when popcount(hist_next ^ SYNC_WORD) <= MAX_ERR.
//   - On match: go to PAYLOAD, bit_cnt=0, tmo_cnt=0, sync_hits++ (saturating).
//   - sr_ena_n stays 1 throughout HUNT; sync bits never reach the shift register.
//  PAYLOAD:
//   - On bit_vld: sr_din <= bit_in and sr_ena_n <= 0 for exactly 1 cycle; bit_cnt++; tmo_cnt=0.
//   - Without bit_vld: tmo_cnt++.
//   - When bit_cnt reaches NDATA: go to DONE.
//   - When tmo_cnt reaches TIMEOUT-1 with no bit_vld: frame_err=1 for 1 cycle, go to HUNT, clear hist.
//  DONE (1 cycle):
//   - frame_done=1. This cycle is the one directly after the final sr_ena_n low cycle.
//   - Next state is HUNT, with hist cleared.
//   - A bit_vld in the DONE cycle is pushed into hist and is not dropped.
//  Boundary cases:
//   - bit_vld on consecutive cycles: supported; sr_ena_n stays low on consecutive cycles.
//   - Sync word appearing inside the payload: ignored; no re-hunt until DONE or timeout.
//   - Overlapping sync patterns in HUNT: detected at the first match.
//   - Reset mid-frame: immediate return to reset values. The partial shift-register contents are
//     not flagged as a frame.
//   - bit_cnt and tmo_cnt width is $clog2(max(NDATA,TIMEOUT)+1); no wrap is possible.
// STRUCTURE
//  Shared package (rx_pkg): state encoding localparams HUNT/PAYLOAD/DONE, default SYNC_WORD,
//   SYNC_LEN, NDATA.
//  Sub-module sync_corr: combinational popcount of hist_next ^ SYNC_WORD, compared with MAX_ERR;
//   output is the single match bit.
//  Top level contains the FSM, counters and output registers.
// TESTING (bench instantiates frame_sync_rx driving shift_reg, NDATA=128)
//  1. Exact match: 0xA5F0 then a 128-bit known pattern, bit_vld every 4 clk
//     -> frame_done pulses once; shift reg dout equals the pattern; sync_hits=1.
//  2. Exact match, back-to-back: the same stream with bit_vld every cycle
//     -> sr_ena_n low for 128 consecutive cycles; frame_done in cycle 129 after the first payload
//        bit_vld.
//  3. MAX_ERR=1: 0xA5F1 (1 bit error) -> locks; 0xA5F3 (2 bit errors) -> stays in HUNT, sync_hits=0.
//  4. Timeout: sync, 10 payload bits, then idle for 1024 clk
//     -> frame_err pulse, busy=0, no frame_done; a following valid frame completes normally.
//  5. Reset mid-frame: assert rst after 60 payload bits -> all outputs at reset values the same
//     cycle; no frame_done.
//  6. Two frames separated by 0 idle bits -> sync_hits=2, two frame_done pulses, each dout correct.

Source files
------------

// File: rtl/frame_sync_rx_pkg.sv
// Shared types and defaults for the frame sync receiver.
package rx_pkg;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        PAYLOAD = 2'd1,
        DONE    = 2'd2
    } state_t;

    localparam int              DEF_NDATA     = 128;
    localparam int              DEF_SYNC_LEN  = 16;
    localparam logic [15:0]     DEF_SYNC_WORD = 16'hA5F0;

    function automatic int max_i(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/frame_sync_rx_sync_corr.sv
// Sync-word correlator: flags a match when the shifted history is within
// MAX_ERR bit errors of the sync word.
module sync_corr
    import rx_pkg::*;
#(
    parameter int                  SYNC_LEN  = DEF_SYNC_LEN,
    parameter logic [SYNC_LEN-1:0] SYNC_WORD = DEF_SYNC_WORD,
    parameter int                  MAX_ERR   = 0
) (
    input  logic [SYNC_LEN-1:0] hist_next,
    output logic                match
);

    localparam int CW = $clog2(SYNC_LEN + 1);

    logic [SYNC_LEN-1:0] diff;
    logic [CW-1:0]       errs;

    assign diff = hist_next ^ SYNC_WORD;

    always_comb begin
        errs = '0;
        for (int i = 0; i < SYNC_LEN; i++)
            errs = errs + CW'(diff[i]);
    end

    assign match = (32'(errs) <= 32'(MAX_ERR));

endmodule

// File: rtl/frame_sync_rx.sv
// Hunts for a sync word, then streams NDATA payload bits into a downstream
// SIPO shift register and flags frame completion or inter-bit timeout.
module frame_sync_rx
    import rx_pkg::*;
#(
    parameter int                  NDATA     = DEF_NDATA,
    parameter int                  SYNC_LEN  = DEF_SYNC_LEN,
    parameter logic [SYNC_LEN-1:0] SYNC_WORD = DEF_SYNC_WORD,
    parameter int                  MAX_ERR   = 0,
    parameter int                  TIMEOUT   = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       bit_in,
    input  logic       bit_vld,
    output logic       sr_din,
    output logic       sr_ena_n,
    output logic       frame_done,
    output logic       frame_err,
    output logic       busy,
    output logic [7:0] sync_hits
);

    localparam int CW = $clog2(max_i(NDATA, TIMEOUT) + 1);

    state_t              state;
    logic [SYNC_LEN-1:0] hist;
    logic [SYNC_LEN-1:0] hist_next;
    logic [SYNC_LEN-1:0] hist_fresh;
    logic [CW-1:0]       bit_cnt;
    logic [CW-1:0]       tmo_cnt;
    logic                match;

    assign hist_next  = {hist[SYNC_LEN-2:0], bit_in};
    // history restarting from zero, keeping a bit that arrives on the frame boundary
    assign hist_fresh = bit_vld ? {{(SYNC_LEN-1){1'b0}}, bit_in} : '0;

    sync_corr #(
        .SYNC_LEN  (SYNC_LEN),
        .SYNC_WORD (SYNC_WORD),
        .MAX_ERR   (MAX_ERR)
    ) u_corr (
        .hist_next (hist_next),
        .match     (match)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= HUNT;
            hist       <= '0;
            bit_cnt    <= '0;
            tmo_cnt    <= '0;
            sr_din     <= 1'b0;
            sr_ena_n   <= 1'b1;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
            sync_hits  <= '0;
        end else begin
            sr_ena_n   <= 1'b1;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            case (state)
                HUNT: begin
                    if (bit_vld) begin
                        hist <= hist_next;
                        if (match) begin
                            state   <= PAYLOAD;
                            busy    <= 1'b1;
                            bit_cnt <= '0;
                            tmo_cnt <= '0;
                            if (sync_hits != 8'hFF)
                                sync_hits <= sync_hits + 8'd1;
                        end
                    end
                end
                PAYLOAD: begin
                    // last shift strobe has just been issued; shift register now full
                    if (bit_cnt == CW'(NDATA)) begin
                        state      <= DONE;
                        frame_done <= 1'b1;
                        hist       <= hist_fresh;
                    end else if (bit_vld) begin
                        sr_din   <= bit_in;
                        sr_ena_n <= 1'b0;
                        bit_cnt  <= bit_cnt + 1'b1;
                        tmo_cnt  <= '0;
                    end else if (tmo_cnt == CW'(TIMEOUT - 1)) begin
                        state     <= HUNT;
                        frame_err <= 1'b1;
                        busy      <= 1'b0;
                        hist      <= '0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                DONE: begin
                    state <= HUNT;
                    busy  <= 1'b0;
                    if (bit_vld)
                        hist <= hist_next;
                end
                default: begin
                    state <= HUNT;
                    busy  <= 1'b0;
                    hist  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frame_sync_rx.sv
// Scoreboard bench: frame events are queued at stimulus time and checked by
// an independent monitor against a downstream 128-bit SIPO register.
module tb_frame_sync_rx;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        bit_in = 1'b0;
    logic        vld0 = 1'b0, vld1 = 1'b0;
    logic        sr_din0, sr_ena_n0, frame_done0, frame_err0, busy0;
    logic        sr_din1, sr_ena_n1, frame_done1, frame_err1, busy1;
    logic [7:0]  sync_hits0, sync_hits1;

    frame_sync_rx #(.NDATA(128), .SYNC_LEN(16), .SYNC_WORD(16'hA5F0), .MAX_ERR(0), .TIMEOUT(1024)) u_dut0 (
        .clk(clk), .rst(rst), .bit_in(bit_in), .bit_vld(vld0),
        .sr_din(sr_din0), .sr_ena_n(sr_ena_n0), .frame_done(frame_done0),
        .frame_err(frame_err0), .busy(busy0), .sync_hits(sync_hits0));

    frame_sync_rx #(.NDATA(128), .SYNC_LEN(16), .SYNC_WORD(16'hA5F0), .MAX_ERR(1), .TIMEOUT(1024)) u_dut1 (
        .clk(clk), .rst(rst), .bit_in(bit_in), .bit_vld(vld1),
        .sr_din(sr_din1), .sr_ena_n(sr_ena_n1), .frame_done(frame_done1),
        .frame_err(frame_err1), .busy(busy1), .sync_hits(sync_hits1));

    always #5 clk = ~clk;

    int cyc = 0;
    always_ff @(posedge clk) cyc <= cyc + 1;

    // downstream shift register, first payload bit ends up in the MSB
    logic [127:0] sr;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)            sr <= '0;
        else if (!sr_ena_n0) sr <= {sr[126:0], sr_din0};
    end

    typedef struct {
        logic         err;
        logic [127:0] dout;
        logic [7:0]   hits;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   n_cmp = 0, n_bad = 0;
    int   run = 0, last_run = 0, done_cyc = -1, n_done = 0, k0 = 0;
    logic [7:0] hits_exp = 8'd0;

    localparam logic [127:0] P1 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    localparam logic [127:0] P2 = 128'hA5F0_0F5A_A5F0_1357_9BDF_2468_ACE0_A5F0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // monitor: pops one expectation per frame_done / frame_err pulse
    initial forever begin
        @(negedge clk);
        if (rst) begin
            if (!sr_ena_n0) run++;
            else if (run > 0) begin last_run = run; run = 0; end
            if (frame_done0 || frame_err0) begin
                if (frame_done0) begin n_done++; done_cyc = cyc; end
                if (exp_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_event: done=%0b err=%0b with no event expected", frame_done0, frame_err0);
                end else begin
                    e = exp_q.pop_front();
                    check("event_is_err", 128'(frame_err0), 128'(e.err));
                    check("event_is_done", 128'(frame_done0), 128'(!e.err));
                    if (!e.err) check("frame_dout", sr, e.dout);
                    check("sync_hits_at_event", 128'(sync_hits0), 128'(e.hits));
                end
            end
        end else begin
            run = 0;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1);
    end

    // entered and left at posedge+1
    task automatic send_bit(input logic b, input int sp, input bit which);
        bit_in = b;
        if (which) vld1 = 1'b1; else vld0 = 1'b1;
        @(posedge clk); #1;
        vld0 = 1'b0; vld1 = 1'b0;
        repeat (sp - 1) begin @(posedge clk); #1; end
    endtask

    task automatic send_word(input logic [15:0] w, input int sp, input bit which);
        for (int i = 15; i >= 0; i--) send_bit(w[i], sp, which);
    endtask

    task automatic send_range(input logic [127:0] p, input int hi, input int lo, input int sp);
        for (int i = hi; i >= lo; i--) send_bit(p[i], sp, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic chk_rst(input string tag);
        check({tag, "_sr_din"},     128'(sr_din0),     128'(0));
        check({tag, "_sr_ena_n"},   128'(sr_ena_n0),   128'(1));
        check({tag, "_frame_done"}, 128'(frame_done0), 128'(0));
        check({tag, "_frame_err"},  128'(frame_err0),  128'(0));
        check({tag, "_busy"},       128'(busy0),       128'(0));
        check({tag, "_sync_hits"},  128'(sync_hits0),  128'(0));
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk_rst("reset");
        check("reset_sync_hits1", 128'(sync_hits1), 128'(0));
        rst = 1'b1;
        idle(2);

        // 1: exact sync, slow bit rate
        hits_exp++; exp_q.push_back('{1'b0, P1, hits_exp});
        send_word(16'hA5F0, 4, 1'b0);
        send_range(P1, 127, 0, 4);
        idle(8);
        check("t1_done_count", 128'(n_done), 128'(1));

        // 2: back-to-back bits, payload contains the sync word
        hits_exp++; exp_q.push_back('{1'b0, P2, hits_exp});
        send_word(16'hA5F0, 1, 1'b0);
        k0 = cyc;
        send_range(P2, 127, 0, 1);
        idle(8);
        check("t2_ena_run_len", 128'(last_run), 128'(128));
        check("t2_done_latency", 128'(done_cyc - k0), 128'(129));
        check("t2_done_count", 128'(n_done), 128'(2));

        // 3: tolerant correlator, 2 errors rejected then 1 error accepted
        send_word(16'hA5F3, 1, 1'b1);
        idle(3);
        check("t3_2err_hits", 128'(sync_hits1), 128'(0));
        check("t3_2err_busy", 128'(busy1), 128'(0));
        send_word(16'h0000, 1, 1'b1);
        send_word(16'hA5F1, 1, 1'b1);
        idle(2);
        check("t3_1err_hits", 128'(sync_hits1), 128'(1));
        check("t3_1err_busy", 128'(busy1), 128'(1));

        // 4: timeout after 10 payload bits, then a clean frame
        hits_exp++; exp_q.push_back('{1'b1, 128'(0), hits_exp});
        send_word(16'hA5F0, 1, 1'b0);
        send_range(P2, 127, 118, 1);
        idle(1040);
        check("t4_busy_after_tmo", 128'(busy0), 128'(0));
        check("t4_done_count", 128'(n_done), 128'(2));
        hits_exp++; exp_q.push_back('{1'b0, P1, hits_exp});
        send_word(16'hA5F0, 2, 1'b0);
        send_range(P1, 127, 0, 2);
        idle(8);
        check("t4_recover_done_count", 128'(n_done), 128'(3));

        // 5: reset after 60 payload bits
        send_word(16'hA5F0, 1, 1'b0);
        send_range(P1, 127, 68, 1);
        check("t5_pre_ena_low", 128'(sr_ena_n0), 128'(0));
        rst = 1'b0;
        #1;
        chk_rst("t5");
        hits_exp = 8'd0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;
        send_range(P1, 67, 0, 1);
        idle(8);
        check("t5_done_count", 128'(n_done), 128'(3));
        check("t5_busy", 128'(busy0), 128'(0));
        check("t5_hits", 128'(sync_hits0), 128'(0));

        // 6: two frames with no gap between them
        hits_exp++; exp_q.push_back('{1'b0, P1, hits_exp});
        hits_exp++; exp_q.push_back('{1'b0, P2, hits_exp});
        send_word(16'hA5F0, 1, 1'b0);
        send_range(P1, 127, 0, 1);
        send_word(16'hA5F0, 1, 1'b0);
        send_range(P2, 127, 0, 1);
        idle(8);
        check("t6_done_count", 128'(n_done), 128'(5));
        check("t6_hits", 128'(sync_hits0), 128'(2));

        check("queue_drained", 128'(exp_q.size()), 128'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
